// File: rtl/cabac_neighbour_ctrl.sv
// Neighbour fetch controller for CABAC context selection: reads the top neighbour
// record from a single-port column RAM, tracks the left neighbour, and buffers write-backs.
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

module cabac_neighbour_ctrl #(
    parameter int ADDR_W = `PIC_X_WIDTH,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] mb_x_i,
    input  logic              mb_y_zero_i,
    input  logic              upd_en_i,
    input  logic [DATA_W-1:0] upd_data_i,
    output logic              busy_o,
    output logic              nb_valid_o,
    output logic [DATA_W-1:0] top_data_o,
    output logic [DATA_W-1:0] left_data_o,
    output logic              mem_r_en_o,
    output logic [ADDR_W-1:0] mem_r_addr_o,
    output logic              mem_w_en_o,
    output logic [ADDR_W-1:0] mem_w_addr_o,
    output logic [DATA_W-1:0] mem_w_data_o,
    input  logic [DATA_W-1:0] mem_r_data_i
);

    typedef enum logic [1:0] {IDLE, RD, CAP, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_x_q;
    logic              row0_q;
    logic              wbuf_valid_q;
    logic [ADDR_W-1:0] wbuf_addr_q;
    logic [DATA_W-1:0] wbuf_data_q;
    logic [DATA_W-1:0] top_q;
    logic [DATA_W-1:0] left_q;
    logic              start_acc;

    assign start_acc = start_i && (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pending write-back always wins the RAM port; the read waits in RD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = mb_y_zero_i ? DONE : RD;
            RD:      if (!wbuf_valid_q) state_d = CAP;
            CAP:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != IDLE);
        nb_valid_o = (state_q == DONE);
        mem_r_en_o = (state_q == RD) && !wbuf_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x_q <= '0;
            row0_q  <= 1'b0;
            top_q   <= '0;
        end else begin
            if (start_acc) begin
                cur_x_q <= mb_x_i;
                row0_q  <= mb_y_zero_i;
                if (mb_y_zero_i) begin
                    top_q <= '0;
                end
            end else if (state_q == CAP && !row0_q) begin
                top_q <= mem_r_data_i;
            end
        end
    end

    // Single-entry write buffer; it drains the cycle after loading, so a
    // back-to-back update simply reloads it and nothing is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbuf_valid_q <= 1'b0;
            wbuf_addr_q  <= '0;
            wbuf_data_q  <= '0;
        end else begin
            wbuf_valid_q <= upd_en_i;
            if (upd_en_i) begin
                wbuf_addr_q <= cur_x_q;
                wbuf_data_q <= upd_data_i;
            end
        end
    end

    // Entering column 0 has no left neighbour, which overrides a same-cycle update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_q <= '0;
        end else if (start_acc && (mb_x_i == '0)) begin
            left_q <= '0;
        end else if (upd_en_i) begin
            left_q <= upd_data_i;
        end
    end

    assign top_data_o   = top_q;
    assign left_data_o  = left_q;
    assign mem_r_addr_o = cur_x_q;
    assign mem_w_en_o   = wbuf_valid_q;
    assign mem_w_addr_o = wbuf_addr_q;
    assign mem_w_data_o = wbuf_data_q;

endmodule

// File: tb/tb_cabac_neighbour_ctrl.sv
// Randomized and directed checks of cabac_neighbour_ctrl against a cycle-level
// behavioural model with a registered-read neighbour RAM in the bench.
`timescale 1ns/1ps

module tb_cabac_neighbour_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] mb_x_i = '0;
    logic          mb_y_zero_i = 1'b0;
    logic          upd_en_i = 1'b0;
    logic [DW-1:0] upd_data_i = '0;
    logic          busy_o, nb_valid_o, mem_r_en_o, mem_w_en_o;
    logic [DW-1:0] top_data_o, left_data_o, mem_w_data_o;
    logic [AW-1:0] mem_r_addr_o, mem_w_addr_o;
    logic [DW-1:0] mem_r_data_i = '0;

    cabac_neighbour_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mb_x_i(mb_x_i),
        .mb_y_zero_i(mb_y_zero_i), .upd_en_i(upd_en_i), .upd_data_i(upd_data_i),
        .busy_o(busy_o), .nb_valid_o(nb_valid_o), .top_data_o(top_data_o),
        .left_data_o(left_data_o), .mem_r_en_o(mem_r_en_o), .mem_r_addr_o(mem_r_addr_o),
        .mem_w_en_o(mem_w_en_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
        .mem_r_data_i(mem_r_data_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Environment RAM, one-cycle registered read
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_w_en_o) ram[mem_w_addr_o] <= mem_w_data_o;
        if (mem_r_en_o) mem_r_data_i <= ram[mem_r_addr_o];
    end

    // Behavioural model: e_* are the outputs expected in the current cycle
    logic [DW-1:0] m_ram [0:(1<<AW)-1];
    logic [AW-1:0] m_cur_x = '0;
    logic [DW-1:0] m_cap = '0;
    bit            m_busy = 0, m_wait = 0, old_busy;
    int            m_cnt = 0;
    bit            e_busy = 0, e_valid = 0, e_ren = 0, e_wen = 0;
    logic [DW-1:0] e_top = '0, e_left = '0, e_wdata = '0;
    logic [AW-1:0] e_raddr = '0, e_waddr = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 0; m_wait = 0; m_cnt = 0; m_cur_x = '0;
            e_busy = 0; e_valid = 0; e_ren = 0; e_wen = 0;
            e_top = '0; e_left = '0; e_wdata = '0; e_raddr = '0; e_waddr = '0;
        end else begin
            old_busy = m_busy;
            if (e_wen) m_ram[e_waddr] = e_wdata;
            if (e_ren) begin
                m_cap  = m_ram[e_raddr];
                m_wait = 0;
                m_cnt  = 2;
            end else if (m_cnt == 2) begin
                m_cnt = 1;
                e_top = m_cap;
            end else if (m_cnt == 1) begin
                m_cnt  = 0;
                m_busy = 0;
            end
            e_wen = upd_en_i;
            if (upd_en_i) begin
                e_waddr = m_cur_x;
                e_wdata = upd_data_i;
                e_left  = upd_data_i;
            end
            if (!old_busy && start_i) begin
                if (mb_x_i == '0) e_left = '0;
                m_cur_x = mb_x_i;
                m_busy  = 1;
                if (mb_y_zero_i) begin
                    e_top = '0;
                    m_cnt = 1;
                end else begin
                    m_wait = 1;
                end
            end
            e_busy  = m_busy;
            e_valid = (m_cnt == 1);
            e_ren   = m_wait && !e_wen;
            e_raddr = m_cur_x;
        end
    end

    int            valid_cnt = 0, ren_cnt = 0, last_valid_cyc = 0;
    logic [DW-1:0] last_top = '0;
    logic [DW-1:0] wlog [$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy_o), 32'(e_busy));
            chk("nb_valid", 32'(nb_valid_o), 32'(e_valid));
            chk("top", 32'(top_data_o), 32'(e_top));
            chk("left", 32'(left_data_o), 32'(e_left));
            chk("r_en", 32'(mem_r_en_o), 32'(e_ren));
            chk("r_addr", 32'(mem_r_addr_o), 32'(e_raddr));
            chk("w_en", 32'(mem_w_en_o), 32'(e_wen));
            chk("w_addr", 32'(mem_w_addr_o), 32'(e_waddr));
            chk("w_data", 32'(mem_w_data_o), 32'(e_wdata));
            chk("strobe_excl", 32'(mem_r_en_o & mem_w_en_o), 32'd0);
            if (nb_valid_o) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                last_top = top_data_o;
            end
            if (mem_r_en_o) ren_cnt++;
            if (mem_w_en_o) wlog.push_back(mem_w_data_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // upd_at: -1 none, 0 in the start cycle, 1 in the cycle after start
    task automatic fetch(input string nm, input logic [AW-1:0] x, input bit y0,
                         input int upd_at, input logic [DW-1:0] d,
                         input int exp_lat, input logic [DW-1:0] exp_top, input int exp_reads);
        int t, v0, r0;
        v0 = valid_cnt; r0 = ren_cnt; t = cyc;
        start_i = 1; mb_x_i = x; mb_y_zero_i = y0;
        upd_en_i = (upd_at == 0); upd_data_i = d;
        tick();
        start_i = 0;
        upd_en_i = (upd_at == 1);
        tick();
        upd_en_i = 0;
        for (int i = 0; i < 12 && valid_cnt == v0; i++) tick();
        chk({nm, "_seen"}, 32'(valid_cnt - v0), 32'd1);
        chk({nm, "_lat"}, 32'(last_valid_cyc - t), 32'(exp_lat));
        chk({nm, "_top"}, 32'(last_top), 32'(exp_top));
        chk({nm, "_reads"}, 32'(ren_cnt - r0), 32'(exp_reads));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, w0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]   = 8'h30 + 8'(i);
            m_ram[i] = 8'h30 + 8'(i);
        end
        ram[5] = 8'hA3;
        m_ram[5] = 8'hA3;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(nb_valid_o), 32'd0);
        chk("rst_top", 32'(top_data_o), 32'd0);
        chk("rst_left", 32'(left_data_o), 32'd0);
        chk("rst_ren", 32'(mem_r_en_o), 32'd0);
        chk("rst_raddr", 32'(mem_r_addr_o), 32'd0);
        chk("rst_wen", 32'(mem_w_en_o), 32'd0);
        chk("rst_wdata", 32'(mem_w_data_o), 32'd0);
        rst = 0;
        tick();

        fetch("ram_path", 4'd5, 1'b0, -1, 8'h00, 3, 8'hA3, 1);
        fetch("row0", 4'd2, 1'b1, -1, 8'h00, 1, 8'h00, 0);
        w0 = wlog.size();
        fetch("stall", 4'd7, 1'b0, 0, 8'h5C, 4, 8'h37, 1);
        chk("stall_wcount", 32'(wlog.size() - w0), 32'd1);
        if (wlog.size() > w0) chk("stall_wdata", 32'(wlog[w0]), 32'h5C);

        // Put 8'h22 into column 5, then update in the read-issue cycle
        fetch("pos5", 4'd5, 1'b0, -1, 8'h00, 3, 8'hA3, 1);
        upd_en_i = 1; upd_data_i = 8'h22;
        tick();
        upd_en_i = 0;
        tick(); tick();
        fetch("rd_vs_upd", 4'd5, 1'b0, 1, 8'h11, 3, 8'h22, 1);
        fetch("after_upd", 4'd5, 1'b0, -1, 8'h00, 3, 8'h11, 1);

        // Back-to-back updates
        w0 = wlog.size();
        upd_en_i = 1; upd_data_i = 8'h01;
        tick();
        upd_data_i = 8'h02;
        tick();
        upd_en_i = 0;
        tick(); tick();
        chk("b2b_count", 32'(wlog.size() - w0), 32'd2);
        if (wlog.size() >= w0 + 2) begin
            chk("b2b_first", 32'(wlog[w0]), 32'h01);
            chk("b2b_second", 32'(wlog[w0 + 1]), 32'h02);
        end
        chk("b2b_left", 32'(left_data_o), 32'h02);

        // Reset while in CAP
        v0 = valid_cnt;
        start_i = 1; mb_x_i = 4'd3; mb_y_zero_i = 0;
        tick();
        start_i = 0;
        tick();
        #2 rst = 1;
        #1;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_valid", 32'(nb_valid_o), 32'd0);
        chk("abort_ren", 32'(mem_r_en_o), 32'd0);
        chk("abort_wen", 32'(mem_w_en_o), 32'd0);
        chk("abort_left", 32'(left_data_o), 32'd0);
        chk("abort_top", 32'(top_data_o), 32'd0);
        tick();
        rst = 0;
        repeat (4) tick();
        chk("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        fetch("post_rst", 4'd3, 1'b0, -1, 8'h00, 3, 8'h33, 1);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            start_i     = ($urandom_range(0, 3) == 0);
            mb_x_i      = AW'($urandom_range(0, 15));
            mb_y_zero_i = ($urandom_range(0, 3) == 0);
            upd_en_i    = ($urandom_range(0, 2) == 0);
            upd_data_i  = DW'($urandom);
            tick();
        end
        start_i = 0; upd_en_i = 0;
        repeat (6) tick();
        chk("rand_idle", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cabac_neighbour_ctrl.md
CABAC_NEIGHBOUR_CTRL -- requirements
Module: cabac_neighbour_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default `PIC_X_WIDTH, width of the column address.
REQ-002 SHALL have parameter DATA_W, default 8, width of one neighbour record.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  single-cycle request to fetch the neighbours of the current block.
REQ-006 SHALL have port mb_x_i  input  ADDR_W  column index of the current block; sampled on start_i.
REQ-007 SHALL have port mb_y_zero_i  input  1  current block is in the top row; sampled on start_i.
REQ-008 SHALL have port upd_en_i  input  1  write back the current block's record.
REQ-009 SHALL have port upd_data_i  input  DATA_W  record to write back.
REQ-010 SHALL have port busy_o  output  1  fetch in progress.
REQ-011 SHALL have port nb_valid_o  output  1  single-cycle pulse; top_data_o and left_data_o are valid.
REQ-012 SHALL have port top_data_o  output  DATA_W  top neighbour record.
REQ-013 SHALL have port left_data_o  output  DATA_W  left neighbour record.
REQ-014 SHALL have ports mem_r_en_o (output, 1) and mem_r_addr_o (output, ADDR_W) as read strobe and read address toward the single-port neighbour RAM.
REQ-015 SHALL have ports mem_w_en_o (output, 1), mem_w_addr_o (output, ADDR_W) and mem_w_data_o (output, DATA_W) as write strobe, write address and write data toward the same RAM.
REQ-016 SHALL have port mem_r_data_i  input  DATA_W  RAM read data; valid exactly 1 cycle after mem_r_en_o.

Function
REQ-017 SHALL implement FSM states IDLE, RD, CAP, DONE; busy_o = (state != IDLE).
REQ-018 In IDLE, start_i SHALL latch mb_x_i into cur_x and mb_y_zero_i into row0.
REQ-019 On start_i in IDLE, the FSM SHALL go to DONE if mb_y_zero_i=1, else to RD.
REQ-020 start_i while busy_o=1 SHALL be ignored.
REQ-021 In RD, with write buffer empty, the block SHALL assert mem_r_en_o=1 and mem_r_addr_o=cur_x for one cycle, then go to CAP.
REQ-022 In RD, with write buffer full, the block SHALL hold mem_r_en_o=0 and remain in RD.
REQ-023 In CAP, the block SHALL load top_data_o from mem_r_data_i at the end of the cycle and go to DONE.
REQ-024 In DONE, nb_valid_o=1 for exactly one cycle; FSM returns to IDLE.
REQ-025 For a row0 fetch, top_data_o SHALL be loaded with 0 on the start_i edge and no RAM read SHALL be issued.
REQ-026 Latency: start_i at cycle T gives nb_valid_o at T+3 (RAM path, no stall), T+1 (row0 path), plus one cycle per RD stall.
REQ-027 upd_en_i SHALL load the single-entry write buffer {valid, addr=cur_x, data=upd_data_i} regardless of FSM state.
REQ-028 A valid write buffer SHALL drive mem_w_en_o=1, mem_w_addr_o=buffer addr, mem_w_data_o=buffer data for one cycle, then clear.
REQ-029 Write buffer SHALL drain every cycle it is valid; upd_en_i in its drain cycle reloads it, so no update is ever dropped.
REQ-030 Write priority: mem_r_en_o and mem_w_en_o SHALL never be 1 in the same cycle.
REQ-031 upd_en_i in the same cycle as the RD read issue SHALL be ordered after the read; the read returns the pre-update value.
REQ-032 A write in the CAP cycle SHALL be permitted; it does not affect the captured value.
REQ-033 left_data_o SHALL load upd_data_i on every upd_en_i.
REQ-034 left_data_o SHALL clear to 0 on an accepted start_i with mb_x_i=0; same-cycle upd_en_i loses to this clear.
REQ-035 mem_r_addr_o SHALL hold cur_x when mem_r_en_o=0; mem_w_* SHALL hold their last values when mem_w_en_o=0.

Reset
REQ-036 On rst=1, the block SHALL asynchronously set state=IDLE, write buffer invalid, cur_x=0, row0=0, and all outputs to 0.
REQ-037 rst asserted mid-fetch or mid-write SHALL abort the operation with no further RAM strobe.
REQ-038 The first start_i after reset release SHALL be accepted normally.

Verification
REQ-039 Bench: mb_x_i=5, mb_y_zero_i=0, RAM[5]=8'hA3, start_i at T -> mem_r_en_o at T+1 (addr 5), nb_valid_o at T+3, top_data_o=8'hA3.
REQ-040 Bench: mb_y_zero_i=1, start_i at T -> nb_valid_o at T+1, top_data_o=0, mem_r_en_o never asserted.
REQ-041 Bench: upd_en_i (8'h5C) one cycle before RD -> mem_w_en_o in RD's first cycle, read delayed one cycle, nb_valid_o at T+4, both strobes never high together.
REQ-042 Bench: upd_en_i (8'h11) in the read-issue cycle at cur_x=5 with RAM[5]=8'h22 -> top_data_o=8'h22, RAM[5]=8'h11 afterwards.
REQ-043 Bench: upd_en_i on two consecutive cycles (8'h01, 8'h02) -> two mem_w_en_o cycles in order, left_data_o=8'h02.
REQ-044 Bench: rst pulse in CAP -> outputs 0 immediately, no nb_valid_o; next start_i completes correctly.
